alu_decode_stage: RTL and testbench
===================================

ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the datapath width of imm and pc.
REQ-002 Port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 Port rst, input, 1 bit: reset is synchronous and active-high.
REQ-004 Port flush, input, 1 bit: discard all buffered entries.
REQ-005 Port in_valid, input, 1 bit: instruction word presented.
REQ-006 Port in_ready, output, 1 bit: stage accepts the word this cycle.
REQ-007 Port in_instr, input, 32 bits: RV32I instruction word.
REQ-008 Port in_pc, input, WIDTH bits: pc of in_instr.
REQ-009 Port out_valid, output, 1 bit: decoded entry presented.
REQ-010 Port out_ready, input, 1 bit: downstream ALU stage accepts the entry.
REQ-011 Port out_op, output, alu_op_t (from cpu_defines.svh): ALU operation.
REQ-012 Port out_rd, out_rs1 and out_rs2, output, 5 bits each: register indices.
REQ-013 Port out_imm, output, WIDTH bits: sign-extended immediate.
REQ-014 Port out_use_imm, output, 1 bit: b operand is out_imm, not rs2.
REQ-015 Port out_illegal, output, 1 bit: instruction is not an ALU op supported by alu_op_t.
REQ-016 Port out_pc, output, WIDTH bits: pc passthrough.

Function
REQ-017 The block SHALL decode opcode 0110011 (R-type) and 0010011 (I-type); every other opcode SHALL set illegal=1 with op=ALU_ADD.
REQ-018 funct3 mapping SHALL be: 000 ADD (R-type funct7 0100000 gives SUB); 001 SLL; 100 XOR; 101 SRL (funct7 0100000 gives SRA); 110 OR; 111 AND.
REQ-019 funct3 010 or 011 (SLT/SLTU), and any nonzero funct7 other than the SUB/SRA cases, SHALL set illegal=1 with op=ALU_ADD.
REQ-020 I-type: use_imm=1; imm = sign-extend instr[31:20] to WIDTH; rs2=0.
REQ-021 I-type shifts: imm = zero-extended instr[24:20]; instr[31:25] SHALL be checked as above.
REQ-022 R-type: use_imm=0; imm=0.
REQ-023 Field extraction SHALL be rd=instr[11:7], rs1=instr[19:15], rs2=instr[24:20].
REQ-024 The decode SHALL be registered; latency SHALL be 1 cycle from an accepted input to out_valid.
REQ-025 Buffering SHALL be a 2-entry skid buffer (main, skid) with states EMPTY, ONE and FULL.
REQ-026 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL; in_ready SHALL be registered and SHALL NOT depend combinationally on out_ready.
REQ-027 EMPTY with accept SHALL go to ONE.
REQ-028 ONE transitions: accept without pop stays ONE if out_ready was high, otherwise goes to FULL (entry into skid); pop without accept goes to EMPTY; accept with pop stays ONE.
REQ-029 FULL with pop SHALL go to ONE, with skid moving to main; no accept is possible in FULL.
REQ-030 out_valid SHALL be 1 in ONE and FULL; output fields SHALL come from main and SHALL stay stable while out_valid=1 and out_ready=0.
REQ-031 Ordering SHALL be strict FIFO; no entry SHALL be dropped or duplicated.
REQ-032 flush SHALL force EMPTY next cycle; an input presented in the flush cycle SHALL be discarded.
REQ-033 flush SHALL take priority over accept and pop.

Reset
REQ-034 When rst=1 at a clock edge, the state SHALL become EMPTY.
REQ-035 Reset values: out_valid=0, in_ready=1 from the first cycle after reset, and all data outputs 0 (op=ALU_ADD).
REQ-036 Reset asserted mid-transfer SHALL discard both entries.
REQ-037 rst SHALL take priority over flush.

Verification
REQ-038 add x3,x1,x2 (0x002081B3), out_ready=1 -> next cycle out_valid=1, op=ALU_ADD, rd=3, rs1=1, rs2=2, use_imm=0, illegal=0.
REQ-039 sub x5,x6,x7 (0x407302B3) -> op=ALU_SUB, rd=5, rs1=6, rs2=7.
REQ-040 addi x1,x0,-1 (0xFFF00093) -> op=ALU_ADD, imm=0xFFFFFFFF, use_imm=1; srai x2,x2,3 (0x40315113) -> op=ALU_SRA, imm=3.
REQ-041 slt (0x0020A1B3) and load opcode 0000011 -> illegal=1, op=ALU_ADD, entry still delivered in order.
REQ-042 Backpressure: stream 4 words with out_ready=0 -> 2 buffered, in_ready=0; then out_ready=1 -> all 4 delivered in order, none lost.
REQ-043 flush in FULL -> next cycle out_valid=0, in_ready=1; rst mid-stream -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/alu_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_defines_pkg
//  Purpose  : ALU operation encoding shared between the decode stage and the
//             ALU stage that consumes its entries.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_defines_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_SLL = 4'd2,
        ALU_XOR = 4'd3,
        ALU_SRL = 4'd4,
        ALU_SRA = 4'd5,
        ALU_OR  = 4'd6,
        ALU_AND = 4'd7
    } alu_op_t;

endpackage : cpu_defines_pkg

// ============================================================================
//  Module   : alu_decode_stage
//  Purpose  : Decodes RV32I register-register (OP) and register-immediate
//             (OP-IMM) ALU instructions into an ALU operation, register
//             indices and a sign-/zero-extended immediate.  The decoded entry
//             is held in a 2-entry skid buffer (main + skid) so the input
//             handshake is fully registered and never depends
//             combinationally on out_ready.
//
//  Ports    :
//    clk          in   clock, all state updates on the rising edge
//    rst          in   synchronous active-high reset (beats flush)
//    flush        in   drop every buffered entry and the word on the input
//    in_valid     in   instruction word presented
//    in_ready     out  stage accepts the word this cycle (registered)
//    in_instr     in   32-bit RV32I instruction word
//    in_pc        in   pc of in_instr
//    out_valid    out  decoded entry presented
//    out_ready    in   downstream ALU stage accepts the entry
//    out_op       out  ALU operation (ALU_ADD when illegal)
//    out_rd/rs1/rs2 out register indices
//    out_imm      out  immediate (0 for register-register ops)
//    out_use_imm  out  b operand is out_imm rather than rs2
//    out_illegal  out  instruction is not a supported ALU operation
//    out_pc       out  pc passthrough
//
//  Revision : 1.0 - initial release
// ============================================================================
module alu_decode_stage
    import cpu_defines_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [WIDTH-1:0] in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output alu_op_t          out_op,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [WIDTH-1:0] out_imm,
    output logic             out_use_imm,
    output logic             out_illegal,
    output logic [WIDTH-1:0] out_pc
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [6:0] C_OPC_OP     = 7'b0110011;
    localparam logic [6:0] C_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] C_F7_ZERO    = 7'b0000000;
    localparam logic [6:0] C_F7_ALT     = 7'b0100000;

    localparam logic [2:0] C_F3_ADD  = 3'b000;
    localparam logic [2:0] C_F3_SLL  = 3'b001;
    localparam logic [2:0] C_F3_XOR  = 3'b100;
    localparam logic [2:0] C_F3_SR   = 3'b101;
    localparam logic [2:0] C_F3_OR   = 3'b110;
    localparam logic [2:0] C_F3_AND  = 3'b111;

    // ------------------------------------------------------------------
    // Buffered entry format
    // ------------------------------------------------------------------
    typedef struct packed {
        alu_op_t          op;
        logic [4:0]       rd;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [WIDTH-1:0] imm;
        logic             use_imm;
        logic             illegal;
        logic [WIDTH-1:0] pc;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Instruction field extraction
    // ------------------------------------------------------------------
    logic [6:0]       w_opcode;
    logic [2:0]       w_funct3;
    logic [6:0]       w_funct7;
    logic             w_is_r;
    logic             w_is_i;
    logic             w_is_shift;
    logic             w_f7_zero;
    logic             w_f7_alt;
    logic [WIDTH-1:0] w_sext_imm;
    logic [WIDTH-1:0] w_shamt_imm;
    entry_t           w_dec;

    assign w_opcode    = in_instr[6:0];
    assign w_funct3    = in_instr[14:12];
    assign w_funct7    = in_instr[31:25];
    assign w_is_r      = (w_opcode == C_OPC_OP);
    assign w_is_i      = (w_opcode == C_OPC_OP_IMM);
    assign w_is_shift  = (w_funct3 == C_F3_SLL) || (w_funct3 == C_F3_SR);
    assign w_f7_zero   = (w_funct7 == C_F7_ZERO);
    assign w_f7_alt    = (w_funct7 == C_F7_ALT);
    assign w_sext_imm  = {{(WIDTH-12){in_instr[31]}}, in_instr[31:20]};
    assign w_shamt_imm = {{(WIDTH-5){1'b0}}, in_instr[24:20]};

    // ------------------------------------------------------------------
    // Combinational decode of the word on the input port.
    // For OP-IMM non-shift instructions instr[31:25] is part of the
    // immediate, so funct7 only qualifies register ops and shifts.
    // Every illegal path leaves op at its ALU_ADD default.
    // ------------------------------------------------------------------
    always_comb begin
        w_dec         = '0;
        w_dec.op      = ALU_ADD;
        w_dec.rd      = in_instr[11:7];
        w_dec.rs1     = in_instr[19:15];
        w_dec.rs2     = in_instr[24:20];
        w_dec.pc      = in_pc;
        w_dec.illegal = 1'b0;

        if (w_is_r || w_is_i) begin
            w_dec.use_imm = w_is_i;
            if (w_is_i) begin
                w_dec.rs2 = 5'd0;
                w_dec.imm = w_is_shift ? w_shamt_imm : w_sext_imm;
            end

            case (w_funct3)
                C_F3_ADD: begin
                    if (w_is_i || w_f7_zero) begin
                        w_dec.op = ALU_ADD;
                    end else if (w_f7_alt) begin
                        w_dec.op = ALU_SUB;
                    end else begin
                        w_dec.illegal = 1'b1;
                    end
                end
                C_F3_SLL: begin
                    if (w_f7_zero) begin
                        w_dec.op = ALU_SLL;
                    end else begin
                        w_dec.illegal = 1'b1;
                    end
                end
                C_F3_XOR: begin
                    if (w_is_i || w_f7_zero) begin
                        w_dec.op = ALU_XOR;
                    end else begin
                        w_dec.illegal = 1'b1;
                    end
                end
                C_F3_SR: begin
                    if (w_f7_zero) begin
                        w_dec.op = ALU_SRL;
                    end else if (w_f7_alt) begin
                        w_dec.op = ALU_SRA;
                    end else begin
                        w_dec.illegal = 1'b1;
                    end
                end
                C_F3_OR: begin
                    if (w_is_i || w_f7_zero) begin
                        w_dec.op = ALU_OR;
                    end else begin
                        w_dec.illegal = 1'b1;
                    end
                end
                C_F3_AND: begin
                    if (w_is_i || w_f7_zero) begin
                        w_dec.op = ALU_AND;
                    end else begin
                        w_dec.illegal = 1'b1;
                    end
                end
                default: begin
                    // SLT / SLTU have no alu_op_t encoding
                    w_dec.illegal = 1'b1;
                end
            endcase
        end else begin
            w_dec.illegal = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Skid buffer control
    // ------------------------------------------------------------------
    state_t r_state;
    entry_t r_main;
    entry_t r_skid;
    logic   r_out_valid;
    logic   r_in_ready;
    logic   w_accept;
    logic   w_pop;

    assign w_accept = in_valid && r_in_ready;
    assign w_pop    = r_out_valid && out_ready;

    // The handshake flags are registered copies of "state != EMPTY" and
    // "state != FULL", updated together with the state so in_ready never
    // sees out_ready through a combinational path.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_main      <= '0;
            r_skid      <= '0;
        end else if (flush) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        r_main      <= w_dec;
                        r_state     <= S_ONE;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_pop) begin
                        r_main <= w_dec;
                    end else if (w_accept) begin
                        // Downstream stalled: park the new word behind main
                        r_skid     <= w_dec;
                        r_state    <= S_FULL;
                        r_in_ready <= 1'b0;
                    end else if (w_pop) begin
                        r_state     <= S_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                S_FULL: begin
                    if (w_pop) begin
                        r_main     <= r_skid;
                        r_state    <= S_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: always presented from the main entry
    // ------------------------------------------------------------------
    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_op      = r_main.op;
    assign out_rd      = r_main.rd;
    assign out_rs1     = r_main.rs1;
    assign out_rs2     = r_main.rs2;
    assign out_imm     = r_main.imm;
    assign out_use_imm = r_main.use_imm;
    assign out_illegal = r_main.illegal;
    assign out_pc      = r_main.pc;

endmodule : alu_decode_stage
`default_nettype wire

// File: tb/tb_alu_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_decode_stage
//  Purpose  : Self-checking bench for alu_decode_stage.  A queue-based model
//             of the buffered entries is compared with the DUT outputs on
//             every falling edge; directed sequences pin known encodings and
//             handshake corner cases, then randomized traffic follows.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_decode_stage;
    import cpu_defines_pkg::*;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [WIDTH-1:0] in_pc;
    logic             out_valid;
    logic             out_ready;
    alu_op_t          out_op;
    logic [4:0]       out_rd;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [WIDTH-1:0] out_imm;
    logic             out_use_imm;
    logic             out_illegal;
    logic [WIDTH-1:0] out_pc;

    alu_decode_stage #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op      (out_op),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_imm     (out_imm),
        .out_use_imm (out_use_imm),
        .out_illegal (out_illegal),
        .out_pc      (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference decode, table driven from the instruction set rules
    // ------------------------------------------------------------------
    typedef struct {
        alu_op_t     op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        use_imm;
        logic        illegal;
        logic [31:0] pc;
    } exp_t;

    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        alu_op_t base_op [8] = '{ALU_ADD, ALU_SLL, ALU_ADD, ALU_ADD,
                                 ALU_XOR, ALU_SRL, ALU_OR,  ALU_AND};
        exp_t e;
        int   f3;
        int   f7;
        bit   is_r;
        bit   is_i;
        bit   shift;
        f3     = int'(ins[14:12]);
        f7     = int'(ins[31:25]);
        is_r   = (ins[6:0] == 7'h33);
        is_i   = (ins[6:0] == 7'h13);
        shift  = (f3 == 1) || (f3 == 5);
        e.rd   = ins[11:7];
        e.rs1  = ins[19:15];
        e.rs2  = is_i ? 5'd0 : ins[24:20];
        e.pc   = pc;
        e.use_imm = is_i;
        if (!is_i)     e.imm = 32'd0;
        else if (shift) e.imm = 32'(ins[24:20]);
        else           e.imm = 32'($signed(ins[31:20]));
        e.op      = ALU_ADD;
        e.illegal = 1'b1;
        if ((is_r || is_i) && f3 != 2 && f3 != 3) begin
            if (is_i && !shift) begin
                e.op = base_op[f3]; e.illegal = 1'b0;
            end else if (f7 == 0) begin
                e.op = base_op[f3]; e.illegal = 1'b0;
            end else if (f7 == 32 && f3 == 5) begin
                e.op = ALU_SRA; e.illegal = 1'b0;
            end else if (f7 == 32 && f3 == 0 && is_r) begin
                e.op = ALU_SUB; e.illegal = 1'b0;
            end
        end
        return e;
    endfunction

    // ------------------------------------------------------------------
    // Per-cycle compare against the model queue
    // ------------------------------------------------------------------
    exp_t q[$];
    exp_t ce;
    bit   started = 1'b0;
    bit   fresh   = 1'b0;
    bit   m_pop;
    bit   m_acc;

    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
            chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
            if (q.size() > 0) begin
                ce = q[0];
                chk("op", 64'(out_op), 64'(ce.op));
                chk("illegal", 64'(out_illegal), 64'(ce.illegal));
                chk("rd", 64'(out_rd), 64'(ce.rd));
                chk("rs1", 64'(out_rs1), 64'(ce.rs1));
                chk("pc", 64'(out_pc), 64'(ce.pc));
                if (!ce.illegal) begin
                    chk("rs2", 64'(out_rs2), 64'(ce.rs2));
                    chk("imm", 64'(out_imm), 64'(ce.imm));
                    chk("use_imm", 64'(out_use_imm), 64'(ce.use_imm));
                end
            end else if (fresh) begin
                chk("reset_data", {out_op, out_rd, out_rs1, out_rs2, out_use_imm, out_illegal},
                    64'd0);
                chk("reset_imm_pc", {out_imm, out_pc}, 64'd0);
            end
        end
        if (rst) begin
            q.delete();
            fresh   = 1'b1;
            started = 1'b1;
        end else if (started) begin
            if (flush) begin
                q.delete();
            end else begin
                m_pop = (q.size() > 0) && out_ready;
                m_acc = in_valid && (q.size() < 2);
                if (m_pop) void'(q.pop_front());
                if (m_acc) begin
                    q.push_back(ref_decode(in_instr, in_pc));
                    fresh = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after the rising edge
    // ------------------------------------------------------------------
    task automatic send(input logic [31:0] ins, input logic [31:0] pc);
        int n;
        bit ok;
        n = 0;
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 50);
        in_valid = 1'b0;
        if (!ok) begin
            n_total++;
            n_bad++;
            $display("FAIL send_timeout: instr %08h not accepted after %0d cycles", ins, n);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    exp_t pe;
    logic [31:0] rnd;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0;
        in_pc = '0; out_ready = 1'b1;

        // Pin the reference decode with hand-computed expectations
        pe = ref_decode(32'h407302B3, 32'd0);
        chk("model_sub", {pe.op, pe.rd, pe.rs1, pe.rs2}, {ALU_SUB, 5'd5, 5'd6, 5'd7});
        pe = ref_decode(32'hFFF00093, 32'd0);
        chk("model_addi_imm", 64'(pe.imm), 64'hFFFF_FFFF);
        pe = ref_decode(32'h40315113, 32'd0);
        chk("model_srai", {pe.op, pe.imm}, {ALU_SRA, 32'd3});
        pe = ref_decode(32'h0020A1B3, 32'd0);
        chk("model_slt", {pe.illegal, pe.op}, {1'b1, ALU_ADD});

        idle(3);
        rst = 1'b0;

        // Directed encodings, checked one cycle after acceptance
        send(32'h002081B3, 32'h100);
        chk("add_valid", 64'(out_valid), 64'd1);
        chk("add_fields", {out_op, out_rd, out_rs1, out_rs2, out_use_imm, out_illegal},
            {ALU_ADD, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0});
        send(32'h407302B3, 32'h104);
        chk("sub_fields", {out_op, out_rd, out_rs1, out_rs2}, {ALU_SUB, 5'd5, 5'd6, 5'd7});
        send(32'hFFF00093, 32'h108);
        chk("addi_fields", {out_op, out_use_imm, out_imm}, {ALU_ADD, 1'b1, 32'hFFFF_FFFF});
        send(32'h40315113, 32'h10C);
        chk("srai_fields", {out_op, out_imm, out_rs2}, {ALU_SRA, 32'd3, 5'd0});
        send(32'h0020A1B3, 32'h110);
        chk("slt_illegal", {out_illegal, out_op, out_pc}, {1'b1, ALU_ADD, 32'h110});
        send(32'h0000A183, 32'h114);
        chk("load_illegal", {out_illegal, out_op, out_pc}, {1'b1, ALU_ADD, 32'h114});
        idle(2);

        // Backpressure: two words fill the buffer, the rest wait
        out_ready = 1'b0;
        send(32'h00208033, 32'h200);
        send(32'h40208033, 32'h204);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        idle(3);
        chk("bp_hold_pc", 64'(out_pc), 64'h200);
        out_ready = 1'b1;
        send(32'h0020C033, 32'h208);
        send(32'h0020E033, 32'h20C);
        idle(4);
        chk("bp_drained", 64'(out_valid), 64'd0);

        // Flush while full; the word on the input is discarded
        out_ready = 1'b0;
        send(32'h00108093, 32'h300);
        send(32'h00208093, 32'h304);
        in_valid = 1'b1; in_instr = 32'h00308093; in_pc = 32'h308;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_state", {out_valid, in_ready}, {1'b0, 1'b1});
        idle(2);

        // Reset mid-stream
        send(32'h00108093, 32'h400);
        send(32'h00208093, 32'h404);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_state", {out_valid, in_ready, out_op, out_rd, out_rs1, out_rs2},
            {1'b0, 1'b1, ALU_ADD, 15'd0});
        chk("rst_data", {out_imm, out_pc}, 64'd0);
        out_ready = 1'b1;
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rnd = $urandom;
            case ($urandom_range(0, 7))
                0, 1, 2: rnd[6:0] = 7'h33;
                3, 4, 5: rnd[6:0] = 7'h13;
                default: ;
            endcase
            case ($urandom_range(0, 3))
                0: rnd[31:25] = 7'h00;
                1: rnd[31:25] = 7'h20;
                default: ;
            endcase
            in_instr  = rnd;
            in_pc     = $urandom;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 49) == 0);
            rst       = ($urandom_range(0, 255) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        idle(5);
        chk("final_empty", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_alu_decode_stage
`default_nettype wire
